// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: holds and edits the alarm time, compares it with the
// running clock, and selects what the 7-segment decoder shows.
//
// state   | meaning
// IDLE    | display running time, watch for alarm match, btn_stop arms/disarms
// SET_MSG | "SEtA" banner for MSG_TICKS seconds before editing
// SET     | decoder shows alarm digits, hour/min buttons edit the alarm
// RING    | buzzer on, display alternates "ALAm" / time every second
module alarm_ctrl #(
  parameter int MSG_TICKS  = 2,
  parameter int RING_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_stop,
  input  logic [5:0] sec,
  input  logic [3:0] t_min2,
  input  logic [3:0] t_min1,
  input  logic [3:0] t_H2,
  input  logic [2:0] t_H1,
  output logic [3:0] d_min2,
  output logic [3:0] d_min1,
  output logic [3:0] d_H2,
  output logic [2:0] d_H1,
  output logic [3:0] Amin2,
  output logic [3:0] Amin1,
  output logic [3:0] AH2,
  output logic [1:0] AH1,
  output logic       condition,
  output logic       alarm_en,
  output logic       buzzer
);

  localparam int MAX_TICKS = (MSG_TICKS > RING_TICKS) ? MSG_TICKS : RING_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] MSG_LOAD  = CW'(MSG_TICKS);
  localparam logic [CW-1:0] RING_LOAD = CW'(RING_TICKS);

  typedef enum logic [1:0] {IDLE, SET_MSG, SET, RING} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_odd;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_odd_nxt;
  logic          w_en_nxt;
  logic          w_match;
  logic [3:0]    w_amin2_nxt, w_amin1_nxt, w_ah2_nxt;
  logic [1:0]    w_ah1_nxt;

  assign w_match = (r_state == IDLE) && alarm_en && tick_1hz && (sec == 6'd0) &&
                   (t_H1 == {1'b0, AH1}) && (t_H2 == AH2) &&
                   (t_min1 == Amin1) && (t_min2 == Amin2);

  // One down-counter serves both the banner and the ring timeout; only one is live at a time.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_odd_nxt   = r_odd;
    w_en_nxt    = alarm_en;
    case (r_state)
      IDLE: begin
        if (w_match) begin
          w_state_nxt = RING;
          w_cnt_nxt   = RING_LOAD;
          w_odd_nxt   = 1'b0;
        end else begin
          if (btn_mode) begin
            w_state_nxt = SET_MSG;
            w_cnt_nxt   = MSG_LOAD;
          end
          if (btn_stop) w_en_nxt = ~alarm_en;
        end
      end
      SET_MSG: begin
        if (btn_mode) begin
          w_state_nxt = SET;
          w_cnt_nxt   = '0;
        end else if (tick_1hz) begin
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = SET;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      SET: begin
        if (btn_mode) begin
          w_state_nxt = IDLE;
          w_en_nxt    = 1'b1;
        end
      end
      RING: begin
        if (btn_stop || (tick_1hz && r_cnt <= CW'(1))) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_odd_nxt   = 1'b0;
        end else if (tick_1hz) begin
          w_cnt_nxt = r_cnt - CW'(1);
          w_odd_nxt = ~r_odd;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // BCD alarm editing; minutes never carry into hours.
  always_comb begin
    w_amin2_nxt = Amin2;
    w_amin1_nxt = Amin1;
    w_ah2_nxt   = AH2;
    w_ah1_nxt   = AH1;
    if (r_state == SET && btn_min) begin
      if (Amin2 == 4'd9) begin
        w_amin2_nxt = 4'd0;
        w_amin1_nxt = (Amin1 == 4'd5) ? 4'd0 : Amin1 + 4'd1;
      end else begin
        w_amin2_nxt = Amin2 + 4'd1;
      end
    end
    if (r_state == SET && btn_hour) begin
      if (AH1 == 2'd2 && AH2 == 4'd3) begin
        w_ah1_nxt = 2'd0;
        w_ah2_nxt = 4'd0;
      end else if (AH2 == 4'd9) begin
        w_ah2_nxt = 4'd0;
        w_ah1_nxt = AH1 + 2'd1;
      end else begin
        w_ah2_nxt = AH2 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_odd     <= 1'b0;
      alarm_en  <= 1'b0;
      condition <= 1'b0;
      buzzer    <= 1'b0;
      Amin2     <= 4'd0;
      Amin1     <= 4'd0;
      AH2       <= 4'd0;
      AH1       <= 2'd0;
      d_min2    <= 4'd0;
      d_min1    <= 4'd0;
      d_H2      <= 4'd0;
      d_H1      <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_odd     <= w_odd_nxt;
      alarm_en  <= w_en_nxt;
      condition <= (w_state_nxt == SET);
      buzzer    <= (w_state_nxt == RING);
      Amin2     <= w_amin2_nxt;
      Amin1     <= w_amin1_nxt;
      AH2       <= w_ah2_nxt;
      AH1       <= w_ah1_nxt;
      if (w_state_nxt == SET_MSG) begin
        d_H1   <= 3'b011;
        d_H2   <= 4'b1010;
        d_min1 <= 4'b1010;
        d_min2 <= 4'b1010;
      end else if (w_state_nxt == RING && !w_odd_nxt) begin
        d_H1   <= 3'b111;
        d_H2   <= 4'b1111;
        d_min1 <= 4'b1111;
        d_min2 <= 4'b1111;
      end else begin
        d_H1   <= t_H1;
        d_H2   <= t_H2;
        d_min1 <= t_min1;
        d_min2 <= t_min2;
      end
    end
  end

endmodule
